// File: rtl/img_stream_gen.sv
// Raster timing generator streaming pixels from a FWFT FIFO into a registered image bus.
// Optional macro IMG_GEN_PATTERN_EN adds pattern_sel, a built-in (h+v) test pattern source.
module img_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
`ifdef IMG_GEN_PATTERN_EN
  input  logic       pattern_sel,
`endif
  input  logic [7:0] src_data,
  input  logic       src_empty,
  output logic       src_rd,
  output logic       img_vsync,
  output logic       img_hsync,
  output logic       img_valid,
  output logic [7:0] img_data,
  output logic       frame_done,
  output logic       underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_MAX   = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [HW-1:0] H_LAST_A = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_LAST_B = HW'(H_BLANK - 1);
  localparam logic [HW-1:0] H_LAST_T = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ONE    = VW'(1);
  localparam logic [VW-1:0] V_LAST_A = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST_B = VW'(V_BLANK - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    VBLANK
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;

  logic       pix_nxt;
  logic       vsync_nxt;
  logic       done_nxt;
  logic       fetch;
  logic [7:0] data_nxt;

  // state/counters describe the cycle currently on the bus; the *_nxt values
  // describe the cycle being prepared, so every output can be registered from them
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = ACTIVE;
          h_nxt     = '0;
          v_nxt     = '0;
        end
      end
      ACTIVE: begin
        if (h_cnt == H_LAST_A) begin
          state_nxt = HBLANK;
          h_nxt     = '0;
        end else begin
          h_nxt = h_cnt + H_ONE;
        end
      end
      HBLANK: begin
        if (h_cnt == H_LAST_B) begin
          h_nxt = '0;
          if (v_cnt == V_LAST_A) begin
            state_nxt = VBLANK;
            v_nxt     = '0;
          end else begin
            state_nxt = ACTIVE;
            v_nxt     = v_cnt + V_ONE;
          end
        end else begin
          h_nxt = h_cnt + H_ONE;
        end
      end
      VBLANK: begin
        if (h_cnt == H_LAST_T) begin
          h_nxt = '0;
          if (v_cnt == V_LAST_B) begin
            v_nxt     = '0;
            state_nxt = enable ? ACTIVE : IDLE;
          end else begin
            v_nxt = v_cnt + V_ONE;
          end
        end else begin
          h_nxt = h_cnt + H_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        h_nxt     = '0;
        v_nxt     = '0;
      end
    endcase
  end

  assign pix_nxt   = (state_nxt == ACTIVE);
  assign vsync_nxt = pix_nxt || ((state_nxt == HBLANK) && (v_nxt != V_LAST_A));
  assign done_nxt  = (state_nxt == VBLANK) && (h_nxt == H_LAST_T) && (v_nxt == V_LAST_B);

`ifdef IMG_GEN_PATTERN_EN
  logic       pat_mode;
  logic       pat_nxt;
  logic       frame_start;
  logic [7:0] pat_data;

  // the pattern choice is latched only when a new frame begins
  assign frame_start = pix_nxt && ((state == IDLE) || (state == VBLANK));
  assign pat_nxt     = frame_start ? pattern_sel : pat_mode;
  assign pat_data    = 8'(h_nxt) + 8'(v_nxt);
  assign fetch       = pix_nxt & ~pat_nxt;
  assign src_rd      = ~rst & fetch & ~src_empty;
  assign data_nxt    = (pix_nxt & pat_nxt) ? pat_data : (src_rd ? src_data : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) pat_mode <= 1'b0;
    else     pat_mode <= pat_nxt;
  end
`else
  assign fetch    = pix_nxt;
  assign src_rd   = ~rst & fetch & ~src_empty;
  assign data_nxt = src_rd ? src_data : 8'h00;
`endif

  // an empty source never stalls the raster; the pixel goes out as 0 and the miss is remembered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      img_vsync  <= 1'b0;
      img_hsync  <= 1'b0;
      img_valid  <= 1'b0;
      img_data   <= 8'h00;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_nxt;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      img_vsync  <= vsync_nxt;
      img_hsync  <= pix_nxt;
      img_valid  <= pix_nxt;
      img_data   <= data_nxt;
      frame_done <= done_nxt;
      underflow  <= underflow | (fetch & src_empty);
    end
  end

endmodule

// File: tb/tb_img_stream_gen.sv
// Scoreboard bench for img_stream_gen: frame-position reference model feeds a queue, a monitor compares.
module tb_img_stream_gen;

  localparam int H_ACTIVE = 4;
  localparam int H_BLANK  = 2;
  localparam int V_ACTIVE = 3;
  localparam int V_BLANK  = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
  localparam int FRAME    = (V_ACTIVE + V_BLANK) * H_TOTAL;
  localparam int VSYNC_END = (V_ACTIVE - 1) * H_TOTAL + H_ACTIVE - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pattern_sel;
  logic [7:0] src_data;
  logic       src_empty;
  logic       src_rd;
  logic       img_vsync, img_hsync, img_valid;
  logic [7:0] img_data;
  logic       frame_done;
  logic       underflow;

  logic       force_empty;
  int         fifo_cnt;
  logic [7:0] fifo_head;
  logic       pop_now;
  logic [7:0] dut_fifo[$];
  logic [7:0] model_fifo[$];

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       vsync;
    logic       hsync;
    logic       valid;
    logic [7:0] data;
    logic       done;
    logic       uf;
  } exp_t;
  exp_t exp_q[$];

  bit m_run;
  int m_pos;
  bit m_uf;
  bit m_pat;

  always #5 clk = ~clk;

  assign src_empty = force_empty || (fifo_cnt == 0);
  assign src_data  = fifo_head;

  img_stream_gen #(
    .H_ACTIVE(H_ACTIVE),
    .H_BLANK (H_BLANK),
    .V_ACTIVE(V_ACTIVE),
    .V_BLANK (V_BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
`ifdef IMG_GEN_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .src_data   (src_data),
    .src_empty  (src_empty),
    .src_rd     (src_rd),
    .img_vsync  (img_vsync),
    .img_hsync  (img_hsync),
    .img_valid  (img_valid),
    .img_data   (img_data),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

  function automatic void refresh_fifo();
    fifo_cnt  = dut_fifo.size();
    fifo_head = (dut_fifo.size() > 0) ? dut_fifo[0] : 8'h00;
  endfunction

  task automatic pushPixel(input logic [7:0] v);
    dut_fifo.push_back(v);
    model_fifo.push_back(v);
    refresh_fifo();
  endtask

  function automatic bit pos_valid(input int p);
    return ((p / H_TOTAL) < V_ACTIVE) && ((p % H_TOTAL) < H_ACTIVE);
  endfunction

  // frame progression in terms of a flat position 0..FRAME-1
  function automatic void model_next(input bit run, input int pos, input bit en,
                                     output bit nrun, output int npos, output bit start);
    start = 1'b0;
    if (!run || pos == FRAME - 1) begin
      nrun  = en;
      npos  = 0;
      start = en;
    end else begin
      nrun = 1'b1;
      npos = pos + 1;
    end
  endfunction

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d @%0t", name, act, expv, $time);
    end
  endtask

  // source FIFO: pops what the DUT requested on the previous edge
  always begin
    @(posedge clk);
    pop_now = src_rd;
    #1;
    if (pop_now && dut_fifo.size() > 0) void'(dut_fifo.pop_front());
    refresh_fifo();
  end

  // reference model: pushes the expected bus contents after each edge
  always @(posedge clk) begin
    exp_t e;
    bit nrun, start;
    int npos, line, col;
    e = '0;
    if (rst) begin
      m_run = 1'b0;
      m_pos = 0;
      m_uf  = 1'b0;
      m_pat = 1'b0;
    end else begin
      model_next(m_run, m_pos, enable, nrun, npos, start);
      m_run = nrun;
      m_pos = npos;
`ifdef IMG_GEN_PATTERN_EN
      if (start) m_pat = pattern_sel;
`endif
      if (m_run) begin
        line    = m_pos / H_TOTAL;
        col     = m_pos % H_TOTAL;
        e.valid = pos_valid(m_pos);
        e.hsync = e.valid;
        e.vsync = (m_pos <= VSYNC_END);
        e.done  = (m_pos == FRAME - 1);
        if (e.valid) begin
          if (m_pat) e.data = 8'(line + col);
          else if (force_empty || model_fifo.size() == 0) m_uf = 1'b1;
          else e.data = model_fifo.pop_front();
        end
      end
    end
    e.uf = m_uf;
    exp_q.push_back(e);
  end

  // monitor: compares away from the active edge
  always @(negedge clk) begin
    exp_t e;
    bit nrun, start, pat;
    int npos;
    model_next(m_run, m_pos, enable, nrun, npos, start);
    pat = m_pat;
`ifdef IMG_GEN_PATTERN_EN
    if (start) pat = pattern_sel;
`endif
    checkOutput("src_rd", int'(src_rd),
                int'(!rst && nrun && pos_valid(npos) && !pat &&
                     !(force_empty || model_fifo.size() == 0)));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("img_vsync", int'(img_vsync), int'(e.vsync));
      checkOutput("img_hsync", int'(img_hsync), int'(e.hsync));
      checkOutput("img_valid", int'(img_valid), int'(e.valid));
      checkOutput("img_data", int'(img_data), int'(e.data));
      checkOutput("frame_done", int'(frame_done), int'(e.done));
      checkOutput("underflow", int'(underflow), int'(e.uf));
    end
  end

  task automatic applyStimulus(input bit r, input bit en, input bit fe, input int cycles);
    rst         = r;
    enable      = en;
    force_empty = fe;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    force_empty = 1'b0;
    pattern_sel = 1'b0;
    refresh_fifo();
    for (int i = 1; i <= 12; i++) pushPixel(8'(i));
    applyStimulus(1, 0, 0, 3);

    // two back-to-back frames; enable dropped at cycle 5 of the second
    applyStimulus(0, 1, 0, 1);
    for (int i = 0; i < 12; i++) pushPixel(8'($urandom_range(0, 255)));
    applyStimulus(0, 1, 0, 29 + 1 + 5);
    applyStimulus(0, 0, 0, 30);

    // source starved for all of line 1
    for (int i = 0; i < 8; i++) pushPixel(8'($urandom_range(0, 255)));
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 5);
    applyStimulus(0, 0, 1, 4);
    applyStimulus(0, 0, 0, 30);

    // reset pulse mid-frame with enable held
    for (int i = 0; i < 12; i++) pushPixel(8'($urandom_range(0, 255)));
    applyStimulus(0, 1, 0, 8);
    applyStimulus(1, 1, 0, 1);
    for (int i = 0; i < 12; i++) pushPixel(8'($urandom_range(0, 255)));
    applyStimulus(0, 1, 0, 35);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 9) < 7) pushPixel(8'($urandom_range(0, 255)));
      applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 19) == 0), 1);
    end

`ifdef IMG_GEN_PATTERN_EN
    applyStimulus(1, 0, 0, 2);
    applyStimulus(0, 0, 0, 2);
    pattern_sel = 1'b1;
    applyStimulus(0, 1, 0, 3);
    pattern_sel = 1'b0;
    applyStimulus(0, 0, 0, 35);
`endif

    applyStimulus(0, 0, 0, 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
